// File: rtl/fc_cls_head.sv
// -----------------------------------------------------------------------------
// fc_cls_head
// Classifier head: a fully connected layer (N_CLASS parallel MACs over an
// N_IN-beat activation stream) followed by bias alignment and a sequential
// argmax. The result is the winning class index and its accumulator value.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      one-cycle pulse, begins an inference when idle
//   busy       high from accepted start until res_valid is issued
//   in_valid   activation beat valid
//   in_ready   block accepts a beat (registered, high throughout ACCUM)
//   in_data    signed activation
//   in_weight  signed weights, class k in bits [k*WW +: WW]
//   bias       signed biases, class k in bits [k*WB +: WB]; stable while busy
//   res_index  winning class (held until next result or reset)
//   res_score  winning accumulator value (held until next result or reset)
//   res_valid  one-cycle result strobe
//
// Build option
//   CLS_SAT_EN  when defined, every accumulator update saturates to the signed
//               WACC-bit range; otherwise updates wrap in two's complement.
// -----------------------------------------------------------------------------
module fc_cls_head #(
    parameter int WI      = 12,
    parameter int WW      = 9,
    parameter int WB      = 9,
    parameter int N_IN    = 128,
    parameter int N_CLASS = 7,
    parameter int INDEX   = 3,
    parameter int WACC    = 28,
    parameter int BSHIFT  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic                      busy,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WI-1:0]      in_data,
    input  logic [WW*N_CLASS-1:0]     in_weight,
    input  logic [WB*N_CLASS-1:0]     bias,
    output logic [INDEX-1:0]          res_index,
    output logic signed [WACC-1:0]    res_score,
    output logic                      res_valid
);

    localparam int WP   = WI + WW;
    localparam int WBS  = WB + BSHIFT;
    localparam int WM1  = (WACC > WP) ? WACC : WP;
    // Working width for one update: wide enough that neither the full product,
    // the shifted bias nor the accumulator is truncated before the add.
    localparam int WE   = ((WM1 > WBS) ? WM1 : WBS) + 1;
    localparam int CNTW = $clog2(N_IN + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCUM  = 3'd1,
        S_BIAS   = 3'd2,
        S_ARGMAX = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Accumulator update: add a WE-bit term, then saturate or wrap to WACC.
    function automatic logic signed [WACC-1:0] acc_add(
        input logic signed [WACC-1:0] a,
        input logic signed [WE-1:0]   b
    );
        logic signed [WE:0] ax;
        logic signed [WE:0] bx;
        logic signed [WE:0] sum;
`ifdef CLS_SAT_EN
        logic signed [WE:0] hi_lim;
        logic signed [WE:0] lo_lim;
`endif
        ax  = {{(WE + 1 - WACC){a[WACC-1]}}, a};
        bx  = {b[WE-1], b};
        sum = ax + bx;
`ifdef CLS_SAT_EN
        hi_lim = {{(WE + 1 - WACC){1'b0}}, 1'b0, {(WACC - 1){1'b1}}};
        lo_lim = {{(WE + 1 - WACC){1'b1}}, 1'b1, {(WACC - 1){1'b0}}};
        if (sum > hi_lim) begin
            acc_add = {1'b0, {(WACC - 1){1'b1}}};
        end else if (sum < lo_lim) begin
            acc_add = {1'b1, {(WACC - 1){1'b0}}};
        end else begin
            acc_add = sum[WACC-1:0];
        end
`else
        acc_add = sum[WACC-1:0];
`endif
    endfunction

    state_t                 state_q, state_d;
    logic [CNTW-1:0]        in_cnt_q, in_cnt_d;
    logic [INDEX-1:0]       cls_cnt_q, cls_cnt_d;
    logic signed [WACC-1:0] acc_q [N_CLASS];
    logic signed [WACC-1:0] acc_d [N_CLASS];
    logic signed [WACC-1:0] best_q, best_d;
    logic [INDEX-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   in_ready_q, in_ready_d;
    logic                   res_valid_q, res_valid_d;
    logic [INDEX-1:0]       res_index_q, res_index_d;
    logic signed [WACC-1:0] res_score_q, res_score_d;

    logic signed [WP-1:0]   data_ext_s;
    logic signed [WE-1:0]   prod_ext_s [N_CLASS];
    logic signed [WE-1:0]   bias_ext_s [N_CLASS];
    logic signed [WACC-1:0] cand_s;

    assign data_ext_s = {{WW{in_data[WI-1]}}, in_data};
    assign cand_s     = acc_q[cls_cnt_q];

    // Per-class full-precision products and aligned biases, widened to WE.
    always_comb begin
        logic signed [WP-1:0] w_ext;
        logic signed [WP-1:0] prod;
        logic signed [WE-1:0] b_ext;
        for (int k = 0; k < N_CLASS; k++) begin
            w_ext         = {{WI{in_weight[k*WW+WW-1]}}, in_weight[k*WW +: WW]};
            prod          = data_ext_s * w_ext;
            prod_ext_s[k] = {{(WE - WP){prod[WP-1]}}, prod};
            b_ext         = {{(WE - WB){bias[k*WB+WB-1]}}, bias[k*WB +: WB]};
            bias_ext_s[k] = b_ext << BSHIFT;
        end
    end

    // Next-state and datapath control for the IDLE/ACCUM/BIAS/ARGMAX/DONE sequence.
    always_comb begin
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        cls_cnt_d   = cls_cnt_q;
        acc_d       = acc_q;
        best_d      = best_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        in_ready_d  = 1'b0;
        res_valid_d = 1'b0;
        res_index_d = res_index_q;
        res_score_d = res_score_q;
        case (state_q)
            S_IDLE: begin
                // A start coinciding with the result strobe is dropped so the
                // earliest new inference begins one cycle after res_valid.
                if (start && !res_valid_q) begin
                    state_d    = S_ACCUM;
                    in_cnt_d   = '0;
                    busy_d     = 1'b1;
                    in_ready_d = 1'b1;
                    for (int k = 0; k < N_CLASS; k++) begin
                        acc_d[k] = '0;
                    end
                end else begin
                    busy_d = 1'b0;
                end
            end
            S_ACCUM: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    for (int k = 0; k < N_CLASS; k++) begin
                        acc_d[k] = acc_add(acc_q[k], prod_ext_s[k]);
                    end
                    in_cnt_d = in_cnt_q + CNTW'(1);
                    if (in_cnt_q == CNTW'(N_IN - 1)) begin
                        state_d    = S_BIAS;
                        in_ready_d = 1'b0;
                    end else begin
                        state_d = S_ACCUM;
                    end
                end else begin
                    state_d = S_ACCUM;
                end
            end
            S_BIAS: begin
                for (int k = 0; k < N_CLASS; k++) begin
                    acc_d[k] = acc_add(acc_q[k], bias_ext_s[k]);
                end
                cls_cnt_d = '0;
                state_d   = S_ARGMAX;
            end
            S_ARGMAX: begin
                // Strict compare: on a tie the earlier (lower) index is kept.
                if (cls_cnt_q == '0) begin
                    best_d = cand_s;
                    idx_d  = '0;
                end else if (cand_s > best_q) begin
                    best_d = cand_s;
                    idx_d  = cls_cnt_q;
                end else begin
                    best_d = best_q;
                end
                if (cls_cnt_q == INDEX'(N_CLASS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    cls_cnt_d = cls_cnt_q + INDEX'(1);
                end
            end
            S_DONE: begin
                res_valid_d = 1'b1;
                res_index_d = idx_q;
                res_score_d = best_q;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, datapath and registered-output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            in_cnt_q    <= '0;
            cls_cnt_q   <= '0;
            best_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_score_q <= '0;
            for (int k = 0; k < N_CLASS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            cls_cnt_q   <= cls_cnt_d;
            best_q      <= best_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_score_q <= res_score_d;
            for (int k = 0; k < N_CLASS; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_index = res_index_q;
    assign res_score = res_score_q;

endmodule

// File: tb/tb_fc_cls_head.sv
module tb_fc_cls_head;

    localparam int WI     = 12;
    localparam int WW     = 9;
    localparam int WB     = 9;
    localparam int N_IN   = 128;
    localparam int NC     = 7;
    localparam int BSHIFT = 8;

    logic clk;
    logic reset;

    // shared stimulus for the default instance (a) and the narrow-accumulator instance (c)
    logic                    start;
    logic                    in_valid;
    logic signed [WI-1:0]    in_data;
    logic [WW*NC-1:0]        in_weight;
    logic [WB*NC-1:0]        bias;

    logic        a_busy, a_in_ready, a_res_valid;
    logic [2:0]  a_res_index;
    logic [27:0] a_res_score;
    logic        c_busy, c_in_ready, c_res_valid;
    logic [2:0]  c_res_index;
    logic [15:0] c_res_score;

    // small instance: 4 inputs, 3 classes
    logic               b_start, b_in_valid, b_busy, b_in_ready, b_res_valid;
    logic signed [11:0] b_in_data;
    logic [26:0]        b_in_weight;
    logic [26:0]        b_bias;
    logic [1:0]         b_res_index;
    logic [27:0]        b_res_score;

    fc_cls_head dut_a (
        .clk(clk), .reset(reset), .start(start), .busy(a_busy),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .in_weight(in_weight), .bias(bias), .res_index(a_res_index),
        .res_score(a_res_score), .res_valid(a_res_valid)
    );

    fc_cls_head #(.WACC(16)) dut_c (
        .clk(clk), .reset(reset), .start(start), .busy(c_busy),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .in_weight(in_weight), .bias(bias), .res_index(c_res_index),
        .res_score(c_res_score), .res_valid(c_res_valid)
    );

    fc_cls_head #(.N_IN(4), .N_CLASS(3), .INDEX(2)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .busy(b_busy),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_weight(b_in_weight), .bias(b_bias), .res_index(b_res_index),
        .res_score(b_res_score), .res_valid(b_res_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int data_q [N_IN];
    int w_q    [N_IN][NC];
    int b_q    [NC];

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // reference: reduce a value to a signed wacc-bit accumulator
    function automatic longint fit(input longint v, input int wacc);
        longint hi;
        longint lo;
        longint r;
        hi = (longint'(1) <<< (wacc - 1)) - 1;
        lo = -hi - 1;
        r  = v;
`ifdef CLS_SAT_EN
        if (r > hi) r = hi;
        if (r < lo) r = lo;
`else
        r = r % (longint'(1) <<< wacc);
        if (r > hi) r = r - (longint'(1) <<< wacc);
        if (r < lo) r = r + (longint'(1) <<< wacc);
`endif
        return r;
    endfunction

    // reference: dot products, bias, argmax with lowest index on ties
    task automatic model(input int wacc, output int idx, output longint best);
        longint acc;
        idx  = 0;
        best = 0;
        for (int k = 0; k < NC; k++) begin
            acc = 0;
            for (int i = 0; i < N_IN; i++) begin
                acc = fit(acc + longint'(data_q[i]) * longint'(w_q[i][k]), wacc);
            end
            acc = fit(acc + (longint'(b_q[k]) * (longint'(1) <<< BSHIFT)), wacc);
            if (k == 0 || acc > best) begin
                best = acc;
                idx  = k;
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N_IN; i++) begin
            data_q[i] = int'($urandom_range(0, 4095)) - 2048;
            for (int k = 0; k < NC; k++) w_q[i][k] = int'($urandom_range(0, 511)) - 256;
        end
        for (int k = 0; k < NC; k++) b_q[k] = int'($urandom_range(0, 511)) - 256;
    endtask

    task automatic drive_beat(input int beat);
        logic [WW*NC-1:0] wv;
        int               t;
        for (int k = 0; k < NC; k++) begin
            t = w_q[beat][k];
            wv[k*WW +: WW] = t[WW-1:0];
        end
        t         = data_q[beat];
        in_data   = t[WI-1:0];
        in_weight = wv;
    endtask

    // mode 0 unbroken stream, 1 backpressure, 2 start pulsed mid-stream, 3 reset after 50 beats
    task automatic run_job(input string tag, input int mode);
        int     beat, cyc, bad_rdy, lat, ia, ic, t;
        longint sa, sc;
        bit     rdy, got;
        logic [WB*NC-1:0] bv;
        for (int k = 0; k < NC; k++) begin
            t = b_q[k];
            bv[k*WB +: WB] = t[WB-1:0];
        end
        bias = bv;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_busy_after_start"}, a_busy, 1);
        beat = 0; cyc = 0; bad_rdy = 0;
        while (beat < N_IN && cyc < 2000) begin
            if (mode == 3 && beat == 50) break;
            rdy = a_in_ready;
            if (a_in_ready !== 1'b1 || c_in_ready !== 1'b1) bad_rdy++;
            in_valid = (mode == 1) ? (cyc % 3 == 0) : 1'b1;
            start    = (mode == 2 && beat == 60);
            drive_beat(beat);
            @(posedge clk);
            if (in_valid && rdy) beat++;
            cyc++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (mode == 3) begin
            reset = 1'b0;
            #1;
            check_eq({tag, "_abort_busy"}, a_busy, 0);
            check_eq({tag, "_abort_valid"}, a_res_valid, 0);
            check_eq({tag, "_abort_ready"}, a_in_ready, 0);
            check_eq({tag, "_abort_index"}, a_res_index, 0);
            check_eq({tag, "_abort_score"}, a_res_score, 0);
            @(negedge clk);
            reset = 1'b1;
            return;
        end
        check_eq({tag, "_ready_in_accum"}, bad_rdy, 0);
        lat = 0; got = 1'b0; bad_rdy = 0;
        while (!got && lat < 40) begin
            if (a_in_ready !== 1'b0) bad_rdy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (a_res_valid === 1'b1) got = 1'b1;
        end
        check_eq({tag, "_latency"}, lat, NC + 2);
        check_eq({tag, "_c_valid"}, c_res_valid, 1);
        check_eq({tag, "_ready_after_accum"}, bad_rdy, 0);
        model(28, ia, sa);
        model(16, ic, sc);
        check_eq({tag, "_a_index"}, a_res_index, ia);
        check_eq({tag, "_a_score"}, longint'($signed(a_res_score)), sa);
        check_eq({tag, "_c_index"}, c_res_index, ic);
        check_eq({tag, "_c_score"}, longint'($signed(c_res_score)), sc);
        // start during the result strobe must be dropped
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, "_pulse_one_cycle"}, a_res_valid, 0);
        check_eq({tag, "_start_on_valid_ignored"}, a_busy, 0);
        check_eq({tag, "_ready_idle"}, a_in_ready, 0);
        check_eq({tag, "_index_held"}, a_res_index, ia);
    endtask

    initial begin
        int lat;
        bit got;
        int bad;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        in_weight = '0; bias = '0;
        b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_weight = '0; b_bias = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", a_busy, 0);
        check_eq("rst_ready", a_in_ready, 0);
        check_eq("rst_valid", a_res_valid, 0);
        check_eq("rst_index", a_res_index, 0);
        check_eq("rst_score", a_res_score, 0);
        check_eq("rst_b_busy", b_busy, 0);
        reset = 1'b1;

        // small instance: data 1..4, weights 1, 2, -1 -> class1 wins with 20
        @(negedge clk);
        b_in_weight = {9'h1FF, 9'd2, 9'd1};
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (b_in_ready !== 1'b1) bad++;
            b_in_valid = 1'b1;
            b_in_data  = 12'(i + 1);
            @(posedge clk);
            @(negedge clk);
        end
        b_in_valid = 1'b0;
        check_eq("small_ready", bad, 0);
        lat = 0; got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (b_res_valid === 1'b1) got = 1'b1;
        end
        check_eq("small_latency", lat, 5);
        check_eq("small_index", b_res_index, 1);
        check_eq("small_score", longint'($signed(b_res_score)), 20);

        fill_random();
        run_job("rand", 0);
        run_job("backpressure", 1);

        // tie between class2 and class4 at 100
        for (int i = 0; i < N_IN; i++) begin
            data_q[i] = (i == 0) ? 1 : 0;
            for (int k = 0; k < NC; k++) w_q[i][k] = (i == 0) ? k * 10 : int'($urandom_range(0, 511)) - 256;
        end
        w_q[0][2] = 100;
        w_q[0][4] = 100;
        for (int k = 0; k < NC; k++) b_q[k] = 0;
        run_job("tie", 0);
        check_eq("tie_index_const", a_res_index, 2);
        check_eq("tie_score_const", longint'($signed(a_res_score)), 100);

        // bias only
        for (int i = 0; i < N_IN; i++) data_q[i] = 0;
        for (int k = 0; k < NC; k++) b_q[k] = (k == 6) ? 1 : 0;
        run_job("bias", 0);
        check_eq("bias_index_const", a_res_index, 6);
        check_eq("bias_score_const", longint'($signed(a_res_score)), 256);

        fill_random();
        run_job("start_mid", 2);
        fill_random();
        run_job("abort", 3);
        fill_random();
        run_job("fresh", 0);

        // overflow of the 16-bit instance
        for (int i = 0; i < N_IN; i++) begin
            data_q[i] = 2047;
            for (int k = 0; k < NC; k++) w_q[i][k] = 255;
        end
        for (int k = 0; k < NC; k++) b_q[k] = 0;
        run_job("overflow", 0);
`ifdef CLS_SAT_EN
        check_eq("overflow_c_const", longint'($signed(c_res_score)), 32767);
`else
        check_eq("overflow_c_const", longint'($signed(c_res_score)), -32640);
`endif
        check_eq("overflow_a_const", longint'($signed(a_res_score)), 66814080);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
